// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, FSM encodings and ASCII digit helper
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_NINE = 8'h39;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } rx_state_t;

   typedef enum logic {
      EXPECT_TENS,
      EXPECT_UNITS
   } pair_ptr_t;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 deserialiser: synchroniser, bit-timing FSM, byte and framing-error pulses
module uart_rx_core #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);
   import uart_pkg::*;

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   rx_state_t            state;
   logic                 rx_meta;
   logic                 rx_s;
   logic [CW-1:0]        clk_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         state      <= ST_IDLE;
         clk_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         data       <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rx_meta    <= rx_in;
         rx_s       <= rx_meta;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;

         case (state)
            ST_IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               if (!rx_s) begin
                  state <= ST_START;
                  busy  <= 1'b1;
               end
            end

            // Mid-start-bit check rejects short low glitches.
            ST_START: begin
               if (clk_cnt == HALF_M1) begin
                  clk_cnt <= '0;
                  if (!rx_s) begin
                     state <= ST_DATA;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            ST_DATA: begin
               if (clk_cnt == FULL_M1) begin
                  clk_cnt <= '0;
                  shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == BIT_LAST) begin
                     state <= ST_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            ST_STOP: begin
               if (clk_cnt == FULL_M1) begin
                  clk_cnt <= '0;
                  if (rx_s) begin
                     data       <= shreg;
                     data_valid <= 1'b1;
                     state      <= ST_IDLE;
                     busy       <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= ST_WAIT_HIGH;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            // A held-low or break line must return high before a new start is armed.
            ST_WAIT_HIGH: begin
               if (rx_s) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_bcd.sv
// rtl/uart_rx_bcd.sv - UART receiver that assembles ASCII digit pairs (tens first) into two BCD digits
module uart_rx_bcd #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy,
   output logic [3:0] bcd0,
   output logic [3:0] bcd1,
   output logic       bcd_valid
);
   import uart_pkg::*;

   pair_ptr_t  ptr;
   logic [3:0] tens_hold;

   uart_rx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_in),
      .data      (data),
      .data_valid(data_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   // Any non-digit byte or bad frame drops a half-received pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= EXPECT_TENS;
         tens_hold <= '0;
         bcd0      <= '0;
         bcd1      <= '0;
         bcd_valid <= 1'b0;
      end else begin
         bcd_valid <= 1'b0;
         if (frame_err) begin
            ptr <= EXPECT_TENS;
         end else if (data_valid) begin
            if (!is_digit(data)) begin
               ptr <= EXPECT_TENS;
            end else if (ptr == EXPECT_TENS) begin
               tens_hold <= data[3:0];
               ptr       <= EXPECT_UNITS;
            end else begin
               bcd1      <= tens_hold;
               bcd0      <= data[3:0];
               bcd_valid <= 1'b1;
               ptr       <= EXPECT_TENS;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_bcd.sv
// tb/tb_uart_rx_bcd.sv - scoreboard bench for uart_rx_bcd with directed and random 8N1 frames
module tb_uart_rx_bcd;

   localparam int CPB     = 16;
   localparam int LAT     = 2 + CPB / 2 + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       busy;
   logic [3:0] bcd0;
   logic [3:0] bcd1;
   logic       bcd_valid;

   uart_rx_bcd #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_in),
      .data      (data),
      .data_valid(data_valid),
      .frame_err (frame_err),
      .busy      (busy),
      .bcd0      (bcd0),
      .bcd1      (bcd1),
      .bcd_valid (bcd_valid)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_err;
      logic [7:0] dat;
      longint     at;
   } ev_t;

   typedef struct {
      logic [3:0] tens;
      logic [3:0] units;
      longint     at;
   } pair_t;

   ev_t   evq[$];
   pair_t pairq[$];

   int n_pass  = 0;
   int n_total = 0;
   int bv_count = 0;

   // Reference model state: last good byte and the pending tens digit (-1 when none).
   logic [7:0] last_good = 8'h00;
   int         pending   = -1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      ev_t   e;
      pair_t p;
      if (data_valid === 1'b1 && frame_err === 1'b1)
         chk("dv_and_ferr_exclusive", 1, 0);
      if (data_valid === 1'b1 || frame_err === 1'b1) begin
         if (evq.size() == 0) begin
            chk("unexpected_byte_event", 1, 0);
         end else begin
            e = evq.pop_front();
            chk(e.is_err ? "ferr_pulse" : "dv_pulse", e.is_err ? frame_err : data_valid, 1);
            chk("byte_data", data, e.dat);
            chk("byte_latency_cycle", cyc, e.at);
         end
      end
      if (bcd_valid === 1'b1) begin
         bv_count++;
         if (pairq.size() == 0) begin
            chk("unexpected_bcd_valid", 1, 0);
         end else begin
            p = pairq.pop_front();
            chk("bcd1", bcd1, p.tens);
            chk("bcd0", bcd0, p.units);
            chk("bcd_latency_cycle", cyc, p.at);
         end
      end
   end

   task automatic hold_line(input logic v, input int n);
      rx_in = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_frame(input logic [7:0] b, input bit stop_ok, input longint s);
      int d;
      if (!stop_ok) begin
         evq.push_back('{1'b1, last_good, s + LAT});
         pending = -1;
         return;
      end
      evq.push_back('{1'b0, b, s + LAT});
      last_good = b;
      d = int'(b) - 48;
      if (d >= 0 && d <= 9) begin
         if (pending < 0) begin
            pending = d;
         end else begin
            pairq.push_back('{4'(pending), 4'(d), s + LAT + 1});
            pending = -1;
         end
      end else begin
         pending = -1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int low_hold);
      model_frame(b, stop_ok, cyc);
      hold_line(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold_line(b[i], CPB);
      hold_line(stop_ok, CPB);
      if (!stop_ok) begin
         hold_line(1'b0, low_hold);
         if (low_hold >= 8) chk("busy_while_line_low", busy, 1);
      end
      rx_in = 1'b1;
   endtask

   initial begin
      int c0;
      logic [7:0] rb;
      bit ok;
      int hold;
      int gap;

      rst   = 1'b1;
      rx_in = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("rst_data", data, 0);
      chk("rst_data_valid", data_valid, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bcd0", bcd0, 0);
      chk("rst_bcd1", bcd1, 0);
      chk("rst_bcd_valid", bcd_valid, 0);
      rst = 1'b0;
      hold_line(1'b1, 20);

      // Single byte with latency check in the monitor.
      send_frame(8'h37, 1'b1, 0);
      hold_line(1'b1, 20);
      send_frame(8'h0A, 1'b1, 0);
      hold_line(1'b1, 20);

      // Digit pair back-to-back.
      c0 = bv_count;
      send_frame(8'h30, 1'b1, 0);
      send_frame(8'h37, 1'b1, 0);
      hold_line(1'b1, 20);
      chk("pair_bcd_valid_count", bv_count - c0, 1);

      // Start-bit glitch.
      hold_line(1'b0, 4);
      hold_line(1'b1, 30);
      chk("glitch_busy_dropped", busy, 0);
      send_frame(8'h35, 1'b1, 0);
      hold_line(1'b1, 20);

      // Framing error with line held low afterwards.
      send_frame(8'h41, 1'b0, 40);
      hold_line(1'b1, 10);
      chk("ferr_busy_dropped", busy, 0);
      send_frame(8'h31, 1'b1, 0);
      hold_line(1'b1, 20);
      send_frame(8'h0A, 1'b1, 0);
      hold_line(1'b1, 20);

      // Pair resync through a non-digit.
      c0 = bv_count;
      send_frame(8'h35, 1'b1, 0);
      send_frame(8'h78, 1'b1, 0);
      send_frame(8'h31, 1'b1, 0);
      send_frame(8'h35, 1'b1, 0);
      hold_line(1'b1, 20);
      chk("resync_bcd_valid_count", bv_count - c0, 1);

      // Reset in the middle of data bit 4; the aborted frame is not modelled.
      send_frame(8'h34, 1'b1, 0);
      hold_line(1'b1, 20);
      hold_line(1'b0, CPB);
      for (int i = 0; i < 4; i++) hold_line(1'b0, CPB);
      hold_line(1'b0, CPB / 2);
      rx_in = 1'b1;
      rst   = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_data", data, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_bcd0", bcd0, 0);
      chk("midrst_bcd1", bcd1, 0);
      chk("midrst_dv", data_valid, 0);
      last_good = 8'h00;
      pending   = -1;
      hold_line(1'b1, 20);
      send_frame(8'h39, 1'b1, 0);
      hold_line(1'b1, 20);

      // Randomised traffic, digits biased so pairs form often.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 0) rb = 8'h30 + 8'($urandom_range(0, 9));
         else rb = 8'($urandom);
         ok   = ($urandom_range(0, 9) != 0);
         hold = ok ? 0 : $urandom_range(0, 30);
         gap  = ok ? $urandom_range(0, 20) : $urandom_range(4, 20);
         send_frame(rb, ok, hold);
         if (gap > 0) hold_line(1'b1, gap);
      end

      hold_line(1'b1, 200);
      chk("events_drained", evq.size(), 0);
      chk("pairs_drained", pairq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
